// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
//   Run controller for the RV32I single-cycle core. It streams a program into
//   instruction memory over a valid/ready port, holds the core in reset for a
//   few cycles, releases it, and counts execution cycles. The run stops when
//   the core PC reaches the programmed halt address or when the cycle budget
//   runs out.
//
// Parameters
//   ADDR_W     instruction-memory word-address width
//   MAX_CYCLES RUN-cycle budget before timeout (>= 1)
//   CNT_W      cycle counter width (must represent MAX_CYCLES)
//   RST_CYCLES cycles core_rst is held after loading (>= 1)
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   start, skip_load, abort  session control
//   load_valid/ready/addr/data/last   program load stream
//   imem_we/waddr/wdata      instruction-memory write port
//   pc, halt_pc              core PC and halt address
//   core_rst, core_run       core reset and core clock-enable
//   busy, done, timeout      session status
//   cycle_cnt                RUN cycles executed
//   pc_sig                   PC signature
//
// Build option
//   CPU_RUN_CTRL_PCSIG_EN    when defined, pc_sig accumulates a rotate-xor
//                            signature of every sampled RUN pc; otherwise
//                            pc_sig is tied to zero.
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
   parameter int ADDR_W     = 7,
   parameter int MAX_CYCLES = 1024,
   parameter int CNT_W      = 16,
   parameter int RST_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              skip_load,
   input  logic              abort,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [31:0]       load_data,
   input  logic              load_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   input  logic [31:0]       pc,
   input  logic [31:0]       halt_pc,
   output logic              core_rst,
   output logic              core_run,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic [31:0]       pc_sig
);

   localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RESET = 3'd2,
      S_RUN   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [RC_W-1:0]   r_rst_cnt;
   logic              r_core_rst;
   logic              r_core_run;
   logic              r_busy;
   logic              r_done;
   logic              r_timeout;
   logic              r_imem_we;
   logic [ADDR_W-1:0] r_imem_waddr;
   logic [31:0]       r_imem_wdata;
   logic [CNT_W-1:0]  r_cycle_cnt;

   logic w_accept;
   logic w_halt;
   logic w_budget;
   logic w_rst_done;
   logic w_start_ok;

   // abort blocks acceptance so a beat offered alongside it is dropped
   assign w_accept   = (r_state == S_LOAD) && load_valid && !abort;
   assign w_halt     = (pc == halt_pc);
   assign w_budget   = (r_cycle_cnt == CNT_W'(MAX_CYCLES - 1));
   assign w_rst_done = (r_rst_cnt == RC_W'(RST_CYCLES - 1));
   assign w_start_ok = start && !abort && ((r_state == S_IDLE) || (r_state == S_DONE));

   assign load_ready = (r_state == S_LOAD);
   assign core_rst   = r_core_rst;
   assign core_run   = r_core_run;
   assign busy       = r_busy;
   assign done       = r_done;
   assign timeout    = r_timeout;
   assign imem_we    = r_imem_we;
   assign imem_waddr = r_imem_waddr;
   assign imem_wdata = r_imem_wdata;
   assign cycle_cnt  = r_cycle_cnt;

   always_comb begin
      w_next = r_state;
      if (abort) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: if (start) w_next = skip_load ? S_RESET : S_LOAD;
            S_LOAD:         if (w_accept && load_last) w_next = S_RESET;
            S_RESET:        if (w_rst_done) w_next = S_RUN;
            // halt match takes precedence over budget expiry (see timeout)
            S_RUN:          if (w_halt || w_budget) w_next = S_DONE;
            default:        w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   // counts cycles spent in RESET; cleared whenever outside it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                    r_rst_cnt <= '0;
      else if (r_state != S_RESET) r_rst_cnt <= '0;
      else if (!w_rst_done)        r_rst_cnt <= r_rst_cnt + 1'b1;
   end

   // status outputs are registered views of the state being entered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_core_rst <= 1'b1;
         r_core_run <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_core_rst <= (w_next == S_IDLE) || (w_next == S_LOAD) || (w_next == S_RESET);
         r_core_run <= (w_next == S_RUN);
         r_busy     <= (w_next == S_LOAD) || (w_next == S_RESET) || (w_next == S_RUN);
         r_done     <= (w_next == S_DONE);
      end
   end

   // write issued the cycle after a beat is accepted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_imem_we    <= 1'b0;
         r_imem_waddr <= '0;
         r_imem_wdata <= '0;
      end else begin
         r_imem_we <= w_accept;
         if (w_accept) begin
            r_imem_waddr <= load_addr;
            r_imem_wdata <= load_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_timeout   <= 1'b0;
         r_cycle_cnt <= '0;
      end else if (abort) begin
         r_timeout   <= 1'b0;
      end else if (w_start_ok) begin
         r_timeout   <= 1'b0;
         r_cycle_cnt <= '0;
      end else if (r_state == S_RUN) begin
         r_cycle_cnt <= r_cycle_cnt + 1'b1;
         if (w_next == S_DONE) r_timeout <= !w_halt;
      end
   end

`ifdef CPU_RUN_CTRL_PCSIG_EN
   logic [31:0] r_pc_sig;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                       r_pc_sig <= '0;
      else if (abort)                                 r_pc_sig <= '0;
      else if (r_state == S_RESET && w_next == S_RUN) r_pc_sig <= '0;
      else if (r_state == S_RUN)                      r_pc_sig <= {r_pc_sig[30:0], r_pc_sig[31]} ^ pc;
   end

   assign pc_sig = r_pc_sig;
`else
   assign pc_sig = 32'h0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl
//   Directed bench for cpu_run_ctrl. Expected instruction-memory writes and
//   run results are queued when stimulus is driven and compared when the DUT
//   produces them.
// ---------------------------------------------------------------------------
module tb_cpu_run_ctrl;

   localparam int ADDR_W     = 7;
   localparam int MAX_CYCLES = 16;
   localparam int CNT_W      = 16;
   localparam int RST_CYCLES = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              skip_load;
   logic              abort;
   logic              load_valid;
   logic              load_ready;
   logic [ADDR_W-1:0] load_addr;
   logic [31:0]       load_data;
   logic              load_last;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [31:0]       imem_wdata;
   logic [31:0]       pc;
   logic [31:0]       halt_pc;
   logic              core_rst;
   logic              core_run;
   logic              busy;
   logic              done;
   logic              timeout;
   logic [CNT_W-1:0]  cycle_cnt;
   logic [31:0]       pc_sig;

   always #5 clk = ~clk;

   cpu_run_ctrl #(
      .ADDR_W(ADDR_W), .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .skip_load(skip_load), .abort(abort),
      .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
      .load_data(load_data), .load_last(load_last), .imem_we(imem_we),
      .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .pc(pc), .halt_pc(halt_pc),
      .core_rst(core_rst), .core_run(core_run), .busy(busy), .done(done),
      .timeout(timeout), .cycle_cnt(cycle_cnt), .pc_sig(pc_sig)
   );

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   typedef struct packed {
      logic [CNT_W-1:0] cnt;
      logic             to;
      logic [31:0]      sig;
   } run_t;

   wr_t  wr_q[$];
   run_t run_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] prog [3] = '{32'h0070_0513, 32'h00A5_0533, 32'h0000_006F};

   function automatic logic [31:0] sig_step(input logic [31:0] s, input logic [31:0] p);
`ifdef CPU_RUN_CTRL_PCSIG_EN
      return {s[30:0], s[31]} ^ p;
`else
      return 32'h0 & (s ^ p);
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_run(input string tag);
      run_t e;
      check({tag, "_done"}, 32'(done), 32'd1);
      if (run_q.size() == 0) begin
         check({tag, "_queued"}, 32'd0, 32'd1);
      end else begin
         e = run_q.pop_front();
         check({tag, "_timeout"}, 32'(timeout), 32'(e.to));
         check({tag, "_cycle_cnt"}, 32'(cycle_cnt), 32'(e.cnt));
         check({tag, "_pc_sig"}, pc_sig, e.sig);
      end
   endtask

   // write monitor: every imem_we pulse must match the oldest queued beat
   always @(posedge clk) begin
      wr_t e;
      #2;
      if (imem_we === 1'b1) begin
         if (wr_q.size() == 0) begin
            check("imem_we_unexpected", 32'd1, 32'd0);
         end else begin
            e = wr_q.pop_front();
            check("wr_addr", 32'(imem_waddr), 32'(e.addr));
            check("wr_data", imem_wdata, e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] sig;

      rst = 1'b0; start = 1'b0; skip_load = 1'b0; abort = 1'b0;
      load_valid = 1'b0; load_addr = '0; load_data = '0; load_last = 1'b0;
      pc = '0; halt_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_core_rst",   32'(core_rst),   32'd1);
      check("rst_core_run",   32'(core_run),   32'd0);
      check("rst_load_ready", 32'(load_ready), 32'd0);
      check("rst_imem_we",    32'(imem_we),    32'd0);
      check("rst_busy",       32'(busy),       32'd0);
      check("rst_done",       32'(done),       32'd0);
      check("rst_timeout",    32'(timeout),    32'd0);
      check("rst_cycle_cnt",  32'(cycle_cnt),  32'd0);
      check("rst_pc_sig",     pc_sig,          32'd0);
      check("rst_waddr",      32'(imem_waddr), 32'd0);
      check("rst_wdata",      imem_wdata,      32'd0);

      @(negedge clk);
      rst = 1'b1;
      tick();
      tick();
      check("idle_core_rst", 32'(core_rst), 32'd1);
      check("idle_busy",     32'(busy),     32'd0);

      // program load
      start = 1'b1; skip_load = 1'b0;
      tick();
      start = 1'b0;
      check("load_ready",    32'(load_ready), 32'd1);
      check("load_busy",     32'(busy),       32'd1);
      check("load_core_rst", 32'(core_rst),   32'd1);
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1;
         load_addr  = ADDR_W'(i);
         load_data  = prog[i];
         load_last  = (i == 2);
         wr_q.push_back({load_addr, load_data});
         tick();
         check("load_we_pulse", 32'(imem_we), 32'd1);
      end
      load_valid = 1'b0; load_last = 1'b0;
      check("reset1_core_rst",   32'(core_rst),   32'd1);
      check("reset1_load_ready", 32'(load_ready), 32'd0);
      pc = 32'h40; halt_pc = 32'h100;
      tick();
      check("reset2_imem_we",  32'(imem_we),  32'd0);
      check("reset2_core_rst", 32'(core_rst), 32'd1);
      check("reset2_core_run", 32'(core_run), 32'd0);
      tick();
      check("run_core_rst",  32'(core_rst),  32'd0);
      check("run_core_run",  32'(core_run),  32'd1);
      check("run_cnt_start", 32'(cycle_cnt), 32'd0);

      // start during RUN is ignored
      start = 1'b1;
      tick();
      start = 1'b0;
      check("run_start_cnt",  32'(cycle_cnt), 32'd1);
      check("run_start_busy", 32'(busy),      32'd1);
      check("run_start_run",  32'(core_run),  32'd1);
      repeat (4) tick();
      check("run_cnt5", 32'(cycle_cnt), 32'd5);

      // asynchronous reset in the middle of a run
      rst = 1'b0;
      #1;
      check("midrst_core_rst",   32'(core_rst),   32'd1);
      check("midrst_core_run",   32'(core_run),   32'd0);
      check("midrst_busy",       32'(busy),       32'd0);
      check("midrst_done",       32'(done),       32'd0);
      check("midrst_cycle_cnt",  32'(cycle_cnt),  32'd0);
      check("midrst_load_ready", 32'(load_ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // halt at pc 8
      halt_pc = 32'h8; pc = 32'h0; skip_load = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      check("halt_reset_busy",  32'(busy),       32'd1);
      check("halt_reset_crst",  32'(core_rst),   32'd1);
      check("halt_reset_ready", 32'(load_ready), 32'd0);
      sig = 32'h0;
      sig = sig_step(sig, 32'h0);
      sig = sig_step(sig, 32'h4);
      sig = sig_step(sig, 32'h8);
      run_q.push_back({CNT_W'(3), 1'b0, sig});
      tick();
      tick();
      check("halt_run_entered", 32'(core_run), 32'd1);
      pc = 32'h0; tick();
      pc = 32'h4; tick();
      check("halt_not_yet", 32'(done), 32'd0);
      pc = 32'h8; tick();
      check_run("halt");
      check("halt_core_run", 32'(core_run), 32'd0);
      check("halt_core_rst", 32'(core_rst), 32'd0);
      check("halt_busy",     32'(busy),     32'd0);
      tick();
      tick();
      check("done_hold",     32'(done),      32'd1);
      check("done_cnt_hold", 32'(cycle_cnt), 32'd3);

      // budget expiry
      halt_pc = 32'h100; pc = 32'h10; start = 1'b1;
      tick();
      start = 1'b0;
      check("to_start_cnt",     32'(cycle_cnt), 32'd0);
      check("to_start_done",    32'(done),      32'd0);
      tick();
      tick();
      sig = 32'h0;
      for (int i = 0; i < MAX_CYCLES; i++) sig = sig_step(sig, 32'h10);
      run_q.push_back({CNT_W'(MAX_CYCLES), 1'b1, sig});
      repeat (MAX_CYCLES - 1) tick();
      check("to_not_yet",  32'(done),      32'd0);
      check("to_cnt15",    32'(cycle_cnt), 32'(MAX_CYCLES - 1));
      tick();
      check_run("timeout");

      // halt on the budget edge wins over timeout
      start = 1'b1;
      tick();
      start = 1'b0;
      check("rerun_timeout_clr", 32'(timeout), 32'd0);
      tick();
      tick();
      run_q.push_back({CNT_W'(MAX_CYCLES), 1'b0, sig});
      repeat (MAX_CYCLES - 1) tick();
      halt_pc = 32'h10;
      tick();
      check_run("halt_vs_budget");

      // abort after one accepted beat
      skip_load = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check("abort_load_ready", 32'(load_ready), 32'd1);
      load_valid = 1'b1; load_addr = 7'd5; load_data = 32'hDEAD_BEEF;
      wr_q.push_back({load_addr, load_data});
      tick();
      check("abort_first_we", 32'(imem_we), 32'd1);
      load_addr = 7'd6; load_data = 32'h1234_5678; abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_load_ready_low", 32'(load_ready), 32'd0);
      check("abort_imem_we",        32'(imem_we),    32'd0);
      check("abort_busy",           32'(busy),       32'd0);
      check("abort_core_rst",       32'(core_rst),   32'd1);
      check("abort_core_run",       32'(core_run),   32'd0);
      check("abort_done",           32'(done),       32'd0);
      check("abort_timeout",        32'(timeout),    32'd0);
      check("abort_pc_sig",         pc_sig,          32'd0);
      tick();
      tick();
      check("abort_no_we", 32'(imem_we), 32'd0);
      load_valid = 1'b0;
      tick();

      check("wr_q_drained",  32'(wr_q.size()),  32'd0);
      check("run_q_drained", 32'(run_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
